// File: rtl/ddc_pkg.sv
// Shared types and default geometry for the DDC converter readout path.
package ddc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_OUT   = 3'd4
  } ddc_state_t;

  localparam int DDC_NCH  = 2;
  localparam int DDC_BITS = 20;
  localparam int DDC_DIV  = 5;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, reset value selectable.
module sync_2ff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ddc_readout_ctrl.sv
// Serial readout of a multi-channel converter frame: handshake with the
// converter, shift in NCH*BITS bits, then hand words out over valid/ready.
module ddc_readout_ctrl
  import ddc_pkg::*;
#(
  parameter  int NCH  = DDC_NCH,
  parameter  int BITS = DDC_BITS,
  parameter  int DIV  = DDC_DIV,
  localparam int CHW  = ch_width(NCH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            dvalid_n,
  input  logic            dout,
  output logic            dclk,
  output logic            dxmit_n,
  output logic [BITS-1:0] out_data,
  output logic [CHW-1:0]  out_ch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            overrun,
  input  logic            ovr_clr,
  output logic [15:0]     frame_cnt,
  output ddc_state_t      dbg_state
);

  localparam int NBITS = NCH * BITS;
  localparam int CNTW  = $clog2(DIV);
  localparam int BCW   = $clog2(NBITS + 1);

  // out_valid/out_ready: a word moves on any clk edge where both are high;
  // while out_valid is high and out_ready low, out_data/out_ch hold steady.

  ddc_state_t        state, state_nxt;
  logic              dv_sync, dv_prev, dv_fall;
  logic [CNTW-1:0]   div_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic              dclk_q;
  logic [NBITS-1:0]  shreg;
  logic [CHW-1:0]    ch_idx;
  logic [15:0]       frame_cnt_q;
  logic              overrun_q;
  logic              div_last, bit_last, ch_last, xfer;

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_dvalid (
    .clk   (clk),
    .reset (reset),
    .d     (dvalid_n),
    .q     (dv_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dv_prev <= 1'b1;
    else       dv_prev <= dv_sync;
  end

  assign dv_fall  = dv_prev & ~dv_sync;
  assign div_last = (div_cnt == CNTW'(DIV - 1));
  assign bit_last = (bit_cnt == BCW'(NBITS - 1));
  assign ch_last  = (ch_idx == CHW'(NCH - 1));
  assign xfer     = (state == ST_OUT) && out_ready;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (dv_fall && enable) state_nxt = ST_SETUP;
      ST_SETUP: if (div_last) state_nxt = ST_SHIFT;
      ST_SHIFT: if (div_last && !dclk_q && bit_last) state_nxt = ST_HOLD;
      ST_HOLD:  if (div_last) state_nxt = ST_OUT;
      ST_OUT:   if (out_ready && ch_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    dxmit_n   = 1'b1;
    busy      = (state != ST_IDLE);
    out_valid = 1'b0;
    out_data  = '0;
    if (state == ST_SETUP || state == ST_SHIFT) dxmit_n = 1'b0;
    if (state == ST_OUT) begin
      out_valid = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (ch_idx == CHW'(i)) out_data = shreg[(NCH-i)*BITS-1 -: BITS];
      end
    end
  end

  // Phase timing: div_cnt restarts on every state change and every DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (state != state_nxt || div_last) begin
      div_cnt <= '0;
    end else if (state == ST_SETUP || state == ST_SHIFT || state == ST_HOLD) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // dclk generation and MSB-first capture on the high->low edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dclk_q  <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (state == ST_SETUP) begin
        bit_cnt <= '0;
        if (div_last) dclk_q <= 1'b1;
      end else if (state == ST_SHIFT && div_last) begin
        if (dclk_q) begin
          dclk_q <= 1'b0;
          shreg  <= {shreg[NBITS-2:0], dout};
        end else if (!bit_last) begin
          dclk_q  <= 1'b1;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Word sequencing, frame count and the sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_idx      <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (xfer) begin
        if (ch_last) begin
          ch_idx      <= '0;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end else begin
          ch_idx <= ch_idx + 1'b1;
        end
      end
      if (dv_fall && state != ST_IDLE) overrun_q <= 1'b1;
      else if (ovr_clr)                overrun_q <= 1'b0;
    end
  end

  assign dclk      = dclk_q;
  assign out_ch    = ch_idx;
  assign frame_cnt = frame_cnt_q;
  assign overrun   = overrun_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_ddc_readout_ctrl.sv
// Bench for ddc_readout_ctrl: converter model, word scoreboard, frame table
// and hand-written sequences for overrun, enable, reset and counter wrap.
module tb_ddc_readout_ctrl;
  import ddc_pkg::*;

  localparam int NCH   = 2;
  localparam int BITS  = 20;
  localparam int DIV   = 5;
  localparam int NBITS = NCH * BITS;
  localparam int CHW   = 1;
  localparam int W     = CHW + BITS;

  logic            clk = 1'b0;
  logic            reset, enable, dvalid_n, dout, out_ready, ovr_clr;
  logic            dclk, dxmit_n, out_valid, busy, overrun;
  logic [BITS-1:0] out_data;
  logic [CHW-1:0]  out_ch;
  logic [15:0]     frame_cnt;
  ddc_state_t      dbg_state;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  logic [NBITS-1:0] conv_word;
  int               conv_base;
  int               pulse_cnt;
  int               stall_left;
  logic [15:0]      exp_frames;

  typedef struct {
    logic [BITS-1:0] w0;
    logic [BITS-1:0] w1;
    int              stall;
    bit              drop_en;
  } frame_vec_t;

  frame_vec_t vecs[4];

  // clock / reset
  always #5 clk = ~clk;

  ddc_readout_ctrl #(.NCH(NCH), .BITS(BITS), .DIV(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .dvalid_n  (dvalid_n),
    .dout      (dout),
    .dclk      (dclk),
    .dxmit_n   (dxmit_n),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
    .frame_cnt (frame_cnt),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Converter model: presents the next bit on each rising dclk.
  task automatic conv_loop();
    int idx;
    forever begin
      @(posedge dclk);
      idx = pulse_cnt - conv_base;
      if (idx >= 0 && idx < NBITS) dout = conv_word[NBITS-1-idx];
      pulse_cnt++;
    end
  endtask

  // Sink: stalls out_ready for stall_left valid cycles.
  task automatic ready_loop();
    forever begin
      @(posedge clk);
      #1;
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
    end
  endtask

  // Scoreboard: pops on each transfer, checks hold stability while stalled.
  task automatic sb_loop();
    logic [W-1:0] exp_w;
    logic [W-1:0] held;
    bit           held_v;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (held_v) check("hold_stable", {out_valid, out_ch, out_data}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {out_ch, out_data}, '1);
          check("unexpected_word_empty_q", 32'd1, {31'd0, busy & 1'b0});
        end else begin
          exp_w = exp_q.pop_front();
          check("word", {out_ch, out_data}, exp_w);
        end
      end
      held_v = out_valid && !out_ready;
      held   = {out_ch, out_data};
    end
  endtask

  // Drives one frame up to the end of the shift phase.
  task automatic start_frame(input logic [BITS-1:0] w0, input logic [BITS-1:0] w1,
                             input int stall, input bit drop_en);
    int n;
    conv_word  = {w0, w1};
    conv_base  = pulse_cnt;
    stall_left = stall;
    exp_q.push_back({1'b0, w0});
    exp_q.push_back({1'b1, w1});
    @(posedge clk); #1 dvalid_n = 1'b0;
    @(posedge clk); #1 check("dxmit_edge1", dxmit_n, 1);
    @(posedge clk); #1 check("dxmit_edge2", dxmit_n, 1);
    @(posedge clk); #1 check("dxmit_edge3", dxmit_n, 0);
    dvalid_n = 1'b1;
    if (drop_en) enable = 1'b0;
    n = 1;
    while (n < 2000) begin
      @(posedge clk); #1;
      if (dxmit_n) break;
      n++;
    end
    check("dxmit_low_cycles", n, DIV + 2 * DIV * NBITS);
    check("dclk_pulses", pulse_cnt - conv_base, NBITS);
  endtask

  // Waits for the words to drain and the FSM to return idle.
  task automatic finish_frame();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("frame_timeout", n < 500, 1);
    exp_frames = exp_frames + 16'd1;
    check("frame_cnt", frame_cnt, exp_frames);
    check("queue_drained", exp_q.size(), 0);
    check("valid_dropped", out_valid, 0);
    enable = 1'b1;
  endtask

  initial begin
    int n;
    bit saw_low;
    reset     = 1'b1;
    enable    = 1'b1;
    dvalid_n  = 1'b1;
    dout      = 1'b0;
    ovr_clr   = 1'b0;
    out_ready = 1'b1;
    conv_word = '0;
    conv_base = 0;
    pulse_cnt = 0;
    stall_left = 0;
    exp_frames = 16'd0;

    vecs[0] = '{w0: 20'hABCDE, w1: 20'h12345, stall: 0, drop_en: 1'b0};
    vecs[1] = '{w0: 20'h00001, w1: 20'hFFFFF, stall: 3, drop_en: 1'b0};
    vecs[2] = '{w0: 20'h55555, w1: 20'hAAAAA, stall: 0, drop_en: 1'b1};
    vecs[3] = '{w0: 20'($urandom_range(0, 20'hFFFFF)), w1: 20'($urandom_range(0, 20'hFFFFF)),
                stall: $urandom_range(0, 4), drop_en: 1'b0};

    fork
      conv_loop();
      ready_loop();
      sb_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_dclk", dclk, 0);
    check("rst_dxmit_n", dxmit_n, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Frame table
    for (int i = 0; i < 4; i++) begin
      start_frame(vecs[i].w0, vecs[i].w1, vecs[i].stall, vecs[i].drop_en);
      finish_frame();
      check("no_overrun", overrun, 0);
    end

    // Long stall on ch0 with a second converter edge inside the window.
    start_frame(20'h0F0F0, 20'h3C3C3, 50, 1'b0);
    n = 0;
    while (!(out_valid && !out_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_reached", n < 100, 1);
    dvalid_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 dvalid_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("overrun_set", overrun, 1);
    check("overrun_no_restart", dxmit_n, 1);
    check("stall_ch0_held", {out_valid, out_ch}, 2'b10);
    finish_frame();
    repeat (10) @(posedge clk);
    #1 check("dropped_edge_idle", busy, 0);

    // ovr_clr coinciding with a new overrun: set wins.
    start_frame(20'h13579, 20'h2468A, 30, 1'b0);
    @(posedge clk); #1 dvalid_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;
    check("ovr_set_wins", overrun, 1);
    dvalid_n = 1'b1;
    finish_frame();
    @(posedge clk); #1 ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;
    check("ovr_clr_alone", overrun, 0);

    // Disabled: converter edges are ignored.
    enable  = 1'b0;
    n       = pulse_cnt;
    saw_low = 1'b0;
    dvalid_n = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (c == 5) dvalid_n = 1'b1;
      if (!dxmit_n || busy) saw_low = 1'b1;
    end
    check("dis_no_xmit", saw_low, 0);
    check("dis_no_dclk", pulse_cnt - n, 0);
    check("dis_no_overrun", overrun, 0);
    enable = 1'b1;

    // Reset at dclk pulse 17: partial frame must never appear.
    conv_word = {20'hDEAD1, 20'hBEEF2};
    conv_base = pulse_cnt;
    @(posedge clk); #1 dvalid_n = 1'b0;
    n = 0;
    while ((pulse_cnt - conv_base) < 17 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("pulse17_reached", n < 1000, 1);
    reset    = 1'b1;
    dvalid_n = 1'b1;
    #1;
    check("midrst_dclk", dclk, 0);
    check("midrst_dxmit_n", dxmit_n, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_overrun", overrun, 0);
    exp_frames = 16'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    start_frame(20'h00001, 20'hFFFFF, 0, 1'b0);
    finish_frame();

    // Counter wrap from a preloaded 0xFFFF.
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_cnt_q;
    @(posedge clk); #1;
    check("preload_frame_cnt", frame_cnt, 16'hFFFF);
    exp_frames = 16'hFFFF;
    start_frame(20'h80000, 20'h00002, 0, 1'b0);
    finish_frame();
    check("wrap_zero", frame_cnt, 16'h0000);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddc_readout_ctrl.md
DDC_READOUT_CTRL -- requirements
Module: ddc_readout_ctrl

Interface
REQ-001 Parameter NCH, default 2, number of converter channels per frame.
REQ-002 Parameter BITS, default 20, bits per channel word.
REQ-003 Parameter DIV, default 5, dclk half-period in clk cycles (minimum 2).
REQ-004 clk  in  1  system clock, 100 MHz nominal.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 enable  in  1  frame acquisition enable, synchronous to clk.
REQ-007 dvalid_n  in  1  converter data-ready strobe, active-low, asynchronous to clk.
REQ-008 dout  in  1  converter serial data, MSB first.
REQ-009 dclk  out  1  serial shift clock to converter.
REQ-010 dxmit_n  out  1  transmit enable to converter, active-low.
REQ-011 out_data  out  BITS  channel word.
REQ-012 out_ch  out  max(1,clog2(NCH))  channel index of out_data.
REQ-013 out_valid / out_ready  out / in  1 each  word handshake; transfer when both high on a clk edge.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 overrun  out  1  sticky frame-lost flag; ovr_clr  in  1  clears it.
REQ-016 frame_cnt  out  16  completed-frame counter.

Function
REQ-017 dvalid_n SHALL pass a 2-flop synchronizer; a falling edge SHALL be detected on the synchronized value.
REQ-018 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD, OUT.
REQ-019 IDLE->SETUP on detected edge with enable=1; dxmit_n SHALL go low on the 3rd clk edge after dvalid_n is first sampled low.
REQ-020 SETUP SHALL last DIV clk cycles with dclk low, then enter SHIFT.
REQ-021 SHIFT SHALL produce exactly NCH*BITS dclk pulses, each DIV cycles high then DIV cycles low.
REQ-022 dout SHALL be sampled on the clk edge that drives dclk high->low; bits shift MSB-first into a NCH*BITS register, channel 0 first.
REQ-023 After the last low phase, dxmit_n SHALL return high and state SHALL enter HOLD for DIV cycles, then OUT.
REQ-024 OUT SHALL present words ch0..ch(NCH-1) in order with out_valid high; out_data/out_ch SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 After the final transfer: frame_cnt increments (wraps 0xFFFF->0x0000), out_valid drops the next cycle, state returns to IDLE.
REQ-026 Edge detected in any state other than IDLE SHALL set overrun and be dropped; in-progress frame unaffected.
REQ-027 Edge detected in IDLE with enable=0 SHALL be ignored, no overrun.
REQ-028 enable deasserted mid-frame SHALL not abort the frame.
REQ-029 ovr_clr and a new overrun on the same cycle: set wins.
REQ-030 dvalid_n returning high before or during SHIFT SHALL be ignored.

Reset
REQ-031 On reset: state IDLE, dclk=0, dxmit_n=1, out_valid=0, out_data=0, out_ch=0, busy=0, overrun=0, frame_cnt=0, synchronizer flops=1.
REQ-032 Reset mid-frame SHALL abort immediately; the partial frame SHALL never be output.

Structure
REQ-033 FSM state enum and default NCH/BITS/DIV SHALL live in shared package ddc_pkg.
REQ-034 Synchronizer SHALL be sub-module sync_2ff (reset value parameterised), reused by other blocks.

Verification (NCH=2, BITS=20, DIV=5)
REQ-035 enable=1, dvalid_n falls, dout drives 0xABCDE then 0x12345 -> dxmit_n low 3 clk later, 40 dclk pulses over 400 clk, words (ch0,0xABCDE),(ch1,0x12345), frame_cnt=1.
REQ-036 out_ready low 50 cycles on ch0 -> out_valid held, data stable; second dvalid_n edge in that window -> overrun=1, frame_cnt=1 after drain.
REQ-037 enable=0, dvalid_n pulses -> dxmit_n stays high, no dclk, overrun=0.
REQ-038 reset asserted at dclk pulse 17 -> all outputs at reset values next edge; next frame 0x00001/0xFFFFF read correctly.
REQ-039 frame_cnt preloaded via 65535 frames (or forced) -> wraps to 0x0000.
REQ-040 overrun=1, ovr_clr pulsed same cycle as new overrun -> overrun stays 1; pulsed alone -> 0.
